// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: opcodes, FSM states and the
// operating modes of the shared multiply/divide sequencer.
package alu_pkg;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_SHRA = 5'b01000;
   localparam logic [4:0] OP_SHL  = 5'b01001;
   localparam logic [4:0] OP_ROR  = 5'b01010;
   localparam logic [4:0] OP_ROL  = 5'b01011;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;

   typedef enum logic [1:0] {MD_NONE, MD_MUL, MD_DIV} md_mode_e;

   function automatic logic is_multicycle(input logic [4:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/multicycle_alu_if.sv
// Request/result bundle between the control unit and the multicycle ALU.
// The control unit is the master; the ALU is the slave.
interface multicycle_alu_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [4:0]       instruction;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] Z_hi;
   logic [WIDTH-1:0] Z_lo;
   logic             div_zero;
   logic             illegal;

   modport master (
      output start, instruction, A, B,
      input  busy, done, Z_hi, Z_lo, div_zero, illegal
   );

   modport slave (
      input  start, instruction, A, B,
      output busy, done, Z_hi, Z_lo, div_zero, illegal
   );
endinterface

// File: rtl/seq_muldiv.sv
// Shared iterative engine: radix-2 Booth multiply or non-restoring divide of
// operand magnitudes. The register pair acc/sreg serves as {hi,lo} or {R,Q}.
module seq_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             go,
   input  md_mode_e         mode,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             fin,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);
   localparam int CW = $clog2(WIDTH + 1);

   md_mode_e         mode_q;
   logic [WIDTH:0]   acc;
   logic [WIDTH:0]   acc_nx;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] sreg_nx;
   logic [WIDTH-1:0] m_q;
   logic             q_m1;
   logic             q_m1_nx;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   booth_sum;
   logic [WIDTH:0]   div_trial;
   logic [WIDTH:0]   m_ext_s;
   logic [WIDTH:0]   m_ext_u;

   assign m_ext_s = {m_q[WIDTH-1], m_q};
   assign m_ext_u = {1'b0, m_q};

   always_comb begin
      acc_nx    = acc;
      sreg_nx   = sreg;
      q_m1_nx   = q_m1;
      booth_sum = acc;
      div_trial = '0;
      if (mode_q == MD_MUL) begin
         case ({sreg[0], q_m1})
            2'b01:   booth_sum = acc + m_ext_s;
            2'b10:   booth_sum = acc - m_ext_s;
            default: booth_sum = acc;
         endcase
         acc_nx  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
         sreg_nx = {booth_sum[0], sreg[WIDTH-1:1]};
         q_m1_nx = sreg[0];
      end else if (mode_q == MD_DIV) begin
         // Sign of the partial remainder picks subtract or add back
         div_trial = acc[WIDTH] ? ({acc[WIDTH-1:0], sreg[WIDTH-1]} + m_ext_u)
                                : ({acc[WIDTH-1:0], sreg[WIDTH-1]} - m_ext_u);
         acc_nx  = div_trial;
         sreg_nx = {sreg[WIDTH-2:0], ~div_trial[WIDTH]};
      end
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         mode_q <= MD_NONE;
         acc    <= '0;
         sreg   <= '0;
         m_q    <= '0;
         q_m1   <= 1'b0;
         cnt    <= '0;
      end else if (go) begin
         mode_q <= mode;
         acc    <= '0;
         q_m1   <= 1'b0;
         cnt    <= (mode == MD_NONE) ? '0 : CW'(WIDTH);
         if (mode == MD_DIV) begin
            sreg <= op_a[WIDTH-1] ? -op_a : op_a;
            m_q  <= op_b[WIDTH-1] ? -op_b : op_b;
         end else begin
            sreg <= op_b;
            m_q  <= op_a;
         end
      end else if (cnt != '0) begin
         acc  <= acc_nx;
         sreg <= sreg_nx;
         q_m1 <= q_m1_nx;
         cnt  <= cnt - CW'(1);
      end
   end

   assign fin = (cnt == '0);

   // Divide mode restores a negative final remainder on the way out
   assign hi_out = (mode_q == MD_DIV && acc[WIDTH]) ? (acc[WIDTH-1:0] + m_q)
                                                    : acc[WIDTH-1:0];
   assign lo_out = sreg;

endmodule

// File: rtl/multicycle_alu.sv
// Registered ALU for the Mini SRC datapath: single-cycle logic/add/shift ops,
// iterative signed multiply and divide through the shared seq_muldiv engine.
module multicycle_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input logic             clock,
   input logic             clear,
   multicycle_alu_if.slave bus
);
   state_e           state;
   state_e           next_state;
   logic             accept;
   md_mode_e         md_mode;
   logic             pend;
   logic [4:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             fin;
   logic [WIDTH-1:0] md_hi;
   logic [WIDTH-1:0] md_lo;
   logic [SHW-1:0]   sh;
   logic [WIDTH-1:0] sc_hi;
   logic [WIDTH-1:0] sc_lo;
   logic             sc_dz;
   logic             sc_ill;
   logic             wr_en;
   logic [WIDTH-1:0] wr_hi;
   logic [WIDTH-1:0] wr_lo;
   logic             wr_dz;
   logic             wr_ill;
   logic [WIDTH-1:0] z_hi_q;
   logic [WIDTH-1:0] z_lo_q;
   logic             done_q;
   logic             dz_q;
   logic             ill_q;

   // Divide by zero never enters the iterative path
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      md_mode    = MD_NONE;
      case (state)
         IDLE: begin
            if (bus.start) begin
               accept = 1'b1;
               if (is_multicycle(bus.instruction) &&
                   !(bus.instruction == OP_DIV && bus.B == '0)) begin
                  md_mode    = (bus.instruction == OP_MUL) ? MD_MUL : MD_DIV;
                  next_state = (bus.instruction == OP_MUL) ? MUL : DIV;
               end
            end
         end
         MUL:     if (fin) next_state = IDLE;
         DIV:     if (fin) next_state = FIX;
         FIX:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state <= IDLE;
         pend  <= 1'b0;
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
      end else begin
         state <= next_state;
         pend  <= accept && (md_mode == MD_NONE);
         if (accept) begin
            op_q <= bus.instruction;
            a_q  <= bus.A;
            b_q  <= bus.B;
         end
      end
   end

   seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clock  (clock),
      .clear  (clear),
      .go     (accept),
      .mode   (md_mode),
      .op_a   (bus.A),
      .op_b   (bus.B),
      .fin    (fin),
      .hi_out (md_hi),
      .lo_out (md_lo)
   );

   assign sh = b_q[SHW-1:0];

   always_comb begin
      sc_hi  = '0;
      sc_lo  = '0;
      sc_dz  = 1'b0;
      sc_ill = 1'b0;
      case (op_q)
         OP_ADD:  sc_lo = a_q + b_q;
         OP_SUB:  sc_lo = a_q - b_q;
         OP_AND:  sc_lo = a_q & b_q;
         OP_OR:   sc_lo = a_q | b_q;
         OP_SHR:  sc_lo = a_q >> sh;
         OP_SHRA: sc_lo = $signed(a_q) >>> sh;
         OP_SHL:  sc_lo = a_q << sh;
         OP_ROR:  sc_lo = (a_q >> sh) | (a_q << (WIDTH - int'(sh)));
         OP_ROL:  sc_lo = (a_q << sh) | (a_q >> (WIDTH - int'(sh)));
         OP_NEG:  sc_lo = -a_q;
         OP_NOT:  sc_lo = ~a_q;
         OP_DIV: begin
            sc_lo = '1;
            sc_hi = a_q;
            sc_dz = 1'b1;
         end
         default: sc_ill = 1'b1;
      endcase
   end

   // FIX applies quotient sign (operand signs differ) and remainder sign (dividend)
   always_comb begin
      wr_en  = 1'b0;
      wr_hi  = '0;
      wr_lo  = '0;
      wr_dz  = 1'b0;
      wr_ill = 1'b0;
      if (pend) begin
         wr_en  = 1'b1;
         wr_hi  = sc_hi;
         wr_lo  = sc_lo;
         wr_dz  = sc_dz;
         wr_ill = sc_ill;
      end else if (state == MUL && fin) begin
         wr_en = 1'b1;
         wr_hi = md_hi;
         wr_lo = md_lo;
      end else if (state == FIX) begin
         wr_en = 1'b1;
         wr_lo = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -md_lo : md_lo;
         wr_hi = a_q[WIDTH-1] ? -md_hi : md_hi;
      end
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         z_hi_q <= '0;
         z_lo_q <= '0;
         done_q <= 1'b0;
         dz_q   <= 1'b0;
         ill_q  <= 1'b0;
      end else begin
         done_q <= wr_en;
         if (wr_en) begin
            z_hi_q <= wr_hi;
            z_lo_q <= wr_lo;
            dz_q   <= wr_dz;
            ill_q  <= wr_ill;
         end else if (accept) begin
            dz_q  <= 1'b0;
            ill_q <= 1'b0;
         end
      end
   end

   assign bus.busy     = (state != IDLE);
   assign bus.done     = done_q;
   assign bus.Z_hi     = z_hi_q;
   assign bus.Z_lo     = z_lo_q;
   assign bus.div_zero = dz_q;
   assign bus.illegal  = ill_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed self-checking bench for multicycle_alu (WIDTH=32): single-cycle ops,
// Booth multiply, signed divide, flags, ignored start and clear abort.
module tb_multicycle_alu;
   import alu_pkg::*;

   localparam int WIDTH = 32;

   logic clock = 1'b0;
   logic clear;
   int   checks = 0;
   int   failures = 0;

   multicycle_alu_if #(.WIDTH(WIDTH)) bus ();

   multicycle_alu #(.WIDTH(WIDTH)) dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Drives one request, then scrambles A/B and counts cycles to done
   task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_cycles);
      @(negedge clock);
      bus.start = 1'b1;
      bus.instruction = op;
      bus.A = a;
      bus.B = b;
      @(negedge clock);
      bus.start = 1'b0;
      bus.A = ~a;
      bus.B = ~b;
      lat = -1;
      busy_cycles = 0;
      for (int n = 1; n <= 100 && lat < 0; n++) begin
         @(negedge clock);
         if (bus.busy === 1'b1) busy_cycles++;
         if (bus.done === 1'b1) lat = n;
      end
   endtask

   task automatic test_reset();
      clear = 1'b1;
      bus.start = 1'b0;
      bus.instruction = '0;
      bus.A = '0;
      bus.B = '0;
      repeat (2) @(negedge clock);
      checks++; if ({bus.busy, bus.done, bus.div_zero, bus.illegal} !== 4'b0000) begin failures++; $display("[TB] FAIL reset_ctrl: got %b expected 0000", {bus.busy, bus.done, bus.div_zero, bus.illegal}); end
      checks++; if (bus.Z_hi !== 32'h0) begin failures++; $display("[TB] FAIL reset_zhi: got %h expected 0", bus.Z_hi); end
      checks++; if (bus.Z_lo !== 32'h0) begin failures++; $display("[TB] FAIL reset_zlo: got %h expected 0", bus.Z_lo); end
      clear = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_back_to_back();
      logic [4:0]  ops [5] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR};
      logic [31:0] exp [5] = '{32'd243, 32'd237, 32'd0, 32'd243, 32'h1E};
      for (int i = 0; i < 7; i++) begin
         @(negedge clock);
         if (i >= 2) begin
            checks++; if (bus.Z_lo !== exp[i-2] || bus.Z_hi !== 32'h0) begin failures++; $display("[TB] FAIL b2b_result[%0d]: got %h_%h expected 00000000_%h", i-2, bus.Z_hi, bus.Z_lo, exp[i-2]); end
            checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL b2b_done_busy[%0d]: got done=%b busy=%b expected done=1 busy=0", i-2, bus.done, bus.busy); end
         end
         if (i < 5) begin
            bus.start = 1'b1;
            bus.instruction = ops[i];
            bus.A = 32'd240;
            bus.B = 32'd3;
         end else begin
            bus.start = 1'b0;
         end
      end
      @(negedge clock);
      checks++; if (bus.done !== 1'b0) begin failures++; $display("[TB] FAIL b2b_done_drop: got %b expected 0", bus.done); end
   endtask

   task automatic test_single_ops();
      logic [4:0]  ops [10] = '{OP_SHR, OP_SHRA, OP_SHRA, OP_SHL, OP_ROL, OP_ROR, OP_ADD, OP_SUB, OP_NEG, OP_NOT};
      logic [31:0] av  [10] = '{32'hF0, 32'h80000000, 32'h7FFFFFF0, 32'h1, 32'h80000001, 32'h1, 32'hFFFFFFFF, 32'h0, 32'd5, 32'h0F0F0F0F};
      logic [31:0] bv  [10] = '{32'h24, 32'd4, 32'd4, 32'd31, 32'd1, 32'd1, 32'd1, 32'd1, 32'd0, 32'd0};
      logic [31:0] exp [10] = '{32'hF, 32'hF8000000, 32'h07FFFFFF, 32'h80000000, 32'h3, 32'h80000000, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFB, 32'hF0F0F0F0};
      int lat;
      int bc;
      for (int i = 0; i < 10; i++) begin
         run_op(ops[i], av[i], bv[i], lat, bc);
         checks++; if (lat != 1 || bc != 0) begin failures++; $display("[TB] FAIL single_timing[%0d]: got lat=%0d busy=%0d expected lat=1 busy=0", i, lat, bc); end
         checks++; if (bus.Z_lo !== exp[i] || bus.Z_hi !== 32'h0) begin failures++; $display("[TB] FAIL single_result[%0d]: got %h_%h expected 00000000_%h", i, bus.Z_hi, bus.Z_lo, exp[i]); end
      end
   endtask

   task automatic test_mul();
      int lat;
      int bc;
      run_op(OP_MUL, 32'd240, 32'd3, lat, bc);
      checks++; if (lat != 33 || bc != 32) begin failures++; $display("[TB] FAIL mul_small_timing: got lat=%0d busy=%0d expected lat=33 busy=32", lat, bc); end
      checks++; if (bus.Z_hi !== 32'h0 || bus.Z_lo !== 32'd720) begin failures++; $display("[TB] FAIL mul_small: got %h_%h expected 00000000_000002d0", bus.Z_hi, bus.Z_lo); end
      @(negedge clock);
      checks++; if (bus.done !== 1'b0) begin failures++; $display("[TB] FAIL mul_done_pulse: got %b expected 0", bus.done); end
      run_op(OP_MUL, 32'hFFFFFFFB, 32'd7, lat, bc);
      checks++; if (lat != 33 || bc != 32) begin failures++; $display("[TB] FAIL mul_neg_timing: got lat=%0d busy=%0d expected lat=33 busy=32", lat, bc); end
      checks++; if (bus.Z_hi !== 32'hFFFFFFFF || bus.Z_lo !== 32'hFFFFFFDD) begin failures++; $display("[TB] FAIL mul_neg: got %h_%h expected ffffffff_ffffffdd", bus.Z_hi, bus.Z_lo); end
   endtask

   task automatic test_div();
      logic [31:0] av  [3] = '{32'd240, 32'hFFFFFFF9, 32'h80000000};
      logic [31:0] bv  [3] = '{32'd3, 32'd2, 32'hFFFFFFFF};
      logic [31:0] elo [3] = '{32'd80, 32'hFFFFFFFD, 32'h80000000};
      logic [31:0] ehi [3] = '{32'd0, 32'hFFFFFFFF, 32'd0};
      int lat;
      int bc;
      for (int i = 0; i < 3; i++) begin
         run_op(OP_DIV, av[i], bv[i], lat, bc);
         checks++; if (lat != 34 || bc != 33) begin failures++; $display("[TB] FAIL div_timing[%0d]: got lat=%0d busy=%0d expected lat=34 busy=33", i, lat, bc); end
         checks++; if (bus.Z_hi !== ehi[i] || bus.Z_lo !== elo[i]) begin failures++; $display("[TB] FAIL div_result[%0d]: got %h_%h expected %h_%h", i, bus.Z_hi, bus.Z_lo, ehi[i], elo[i]); end
      end
   endtask

   task automatic test_flags();
      int lat;
      int bc;
      run_op(OP_DIV, 32'd9, 32'd0, lat, bc);
      checks++; if (lat != 1 || bc != 0) begin failures++; $display("[TB] FAIL divzero_timing: got lat=%0d busy=%0d expected lat=1 busy=0", lat, bc); end
      checks++; if (bus.div_zero !== 1'b1 || bus.illegal !== 1'b0) begin failures++; $display("[TB] FAIL divzero_flags: got dz=%b ill=%b expected dz=1 ill=0", bus.div_zero, bus.illegal); end
      checks++; if (bus.Z_hi !== 32'd9 || bus.Z_lo !== 32'hFFFFFFFF) begin failures++; $display("[TB] FAIL divzero_result: got %h_%h expected 00000009_ffffffff", bus.Z_hi, bus.Z_lo); end
      run_op(5'b11111, 32'd3, 32'd4, lat, bc);
      checks++; if (lat != 1) begin failures++; $display("[TB] FAIL illegal_timing: got lat=%0d expected 1", lat); end
      checks++; if (bus.illegal !== 1'b1 || bus.div_zero !== 1'b0) begin failures++; $display("[TB] FAIL illegal_flags: got ill=%b dz=%b expected ill=1 dz=0", bus.illegal, bus.div_zero); end
      checks++; if (bus.Z_hi !== 32'h0 || bus.Z_lo !== 32'h0) begin failures++; $display("[TB] FAIL illegal_result: got %h_%h expected 0", bus.Z_hi, bus.Z_lo); end
      run_op(OP_ADD, 32'd5, 32'd6, lat, bc);
      checks++; if (bus.illegal !== 1'b0 || bus.div_zero !== 1'b0 || bus.Z_lo !== 32'd11) begin failures++; $display("[TB] FAIL flags_clear: got ill=%b dz=%b lo=%h expected ill=0 dz=0 lo=0000000b", bus.illegal, bus.div_zero, bus.Z_lo); end
   endtask

   task automatic test_ignore_start();
      int lat;
      @(negedge clock);
      bus.start = 1'b1;
      bus.instruction = OP_MUL;
      bus.A = 32'd240;
      bus.B = 32'd3;
      @(negedge clock);
      bus.start = 1'b0;
      lat = -1;
      for (int n = 1; n <= 100 && lat < 0; n++) begin
         @(negedge clock);
         if (n == 5) begin
            bus.start = 1'b1;
            bus.instruction = OP_ADD;
            bus.A = 32'd1000;
            bus.B = 32'd2000;
         end else begin
            bus.start = 1'b0;
         end
         if (bus.done === 1'b1) lat = n;
      end
      bus.start = 1'b0;
      checks++; if (lat != 33) begin failures++; $display("[TB] FAIL ignore_timing: got lat=%0d expected 33", lat); end
      checks++; if (bus.Z_hi !== 32'h0 || bus.Z_lo !== 32'd720) begin failures++; $display("[TB] FAIL ignore_result: got %h_%h expected 00000000_000002d0", bus.Z_hi, bus.Z_lo); end
      @(negedge clock);
      checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.Z_lo !== 32'd720) begin failures++; $display("[TB] FAIL ignore_no_queue: got done=%b busy=%b lo=%h expected done=0 busy=0 lo=000002d0", bus.done, bus.busy, bus.Z_lo); end
   endtask

   task automatic test_clear_abort();
      int lat;
      int bc;
      @(negedge clock);
      bus.start = 1'b1;
      bus.instruction = OP_DIV;
      bus.A = 32'd240;
      bus.B = 32'd3;
      @(negedge clock);
      bus.start = 1'b0;
      repeat (9) @(negedge clock);
      checks++; if (bus.busy !== 1'b1) begin failures++; $display("[TB] FAIL abort_inflight: got busy=%b expected 1", bus.busy); end
      clear = 1'b1;
      #1;
      checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.Z_hi !== 32'h0 || bus.Z_lo !== 32'h0) begin failures++; $display("[TB] FAIL abort_clear: got busy=%b done=%b z=%h_%h expected all 0", bus.busy, bus.done, bus.Z_hi, bus.Z_lo); end
      @(negedge clock);
      clear = 1'b0;
      repeat (2) @(negedge clock);
      checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_no_done: got done=%b busy=%b expected 0 0", bus.done, bus.busy); end
      run_op(OP_ADD, 32'd1, 32'd1, lat, bc);
      checks++; if (lat != 1 || bus.Z_lo !== 32'd2) begin failures++; $display("[TB] FAIL abort_recover: got lat=%0d lo=%h expected lat=1 lo=00000002", lat, bus.Z_lo); end
   endtask

   initial begin
      $display("[TB] starting multicycle_alu bench");
      test_reset();
      test_back_to_back();
      test_single_ops();
      test_mul();
      test_div();
      test_flags();
      test_ignore_start();
      test_clear_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
